// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI link arbiter: FSM encoding,
// requester indices and the grant helper.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_HOLD      = 3'd4
  } arb_state_e;

  localparam int unsigned REQ_AUDIO  = 0;
  localparam int unsigned REQ_CFG    = 1;
  localparam logic [1:0]  GRANT_NONE = 2'b00;

  function automatic logic [1:0] grant_of(input logic idx);
    logic [1:0] g;
    g      = 2'b00;
    g[idx] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/spi_arb_req_slot.sv
// One requester's start capture: holds the byte, keeps the pending flag until
// the arbiter issues it, and flags starts that arrive while the byte is still owed.
module spi_arb_req_slot
  import spi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       clear_i,
  input  logic       inflight_i,
  output logic       pending_o,
  output logic [7:0] data_o,
  output logic       overrun_o
);

  logic       pending_q, pending_d;
  logic [7:0] data_q, data_d;
  logic       overrun_q, overrun_d;
  logic       accept_s;

  // Next-state for the pending flag, held byte and overrun pulse
  always_comb begin
    accept_s  = start_i & ~pending_q & ~inflight_i;
    pending_d = pending_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (accept_s) begin
      pending_d = 1'b1;
      data_d    = data_i;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (start_i && !accept_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/spi_link_arbiter.sv
// Shares one SPI byte transceiver between the audio path (req0) and the radio
// config poller (req1). Define SPI_ARB_ROUND_ROBIN_EN for alternating priority.
module spi_link_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned BUSY_RISE_TIMEOUT = 4,
  parameter int unsigned LOCK_TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_tx_start,
  input  logic [7:0] r0_tx_data,
  input  logic       r0_lock,
  output logic       r0_tx_busy,
  output logic [7:0] r0_rx_data,
  output logic       r0_rx_done,
  input  logic       r1_tx_start,
  input  logic [7:0] r1_tx_data,
  input  logic       r1_lock,
  output logic       r1_tx_busy,
  output logic [7:0] r1_rx_data,
  output logic       r1_rx_done,
  output logic       spi_tx_start,
  output logic [7:0] spi_tx_data,
  input  logic       spi_tx_busy,
  input  logic [7:0] spi_rx_data,
  input  logic       spi_rx_done,
  output logic [1:0] grant,
  output logic       lock_err,
  output logic       overrun_err
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e   state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         lock_err_q, lock_err_d;
  logic [7:0]   rx0_data_q, rx0_data_d, rx1_data_q, rx1_data_d;
  logic         rx0_done_q, rx0_done_d, rx1_done_q, rx1_done_d;

  logic [1:0]   pending_s, clear_s, inflight_s, overrun_s;
  logic [7:0]   slot_data_s [2];
  logic         xfer_s, owner_s, owner_lock_s, pick_s, prio_s, rx_target_s;

  assign xfer_s     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RISE) || (state_q == ST_WAIT_FALL);
  assign owner_s    = grant_q[REQ_CFG];
  assign clear_s    = (state_q == ST_ISSUE) ? grant_q : 2'b00;
  assign inflight_s = xfer_s ? grant_q : 2'b00;

  spi_arb_req_slot u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (r0_tx_start),
    .data_i     (r0_tx_data),
    .clear_i    (clear_s[REQ_AUDIO]),
    .inflight_i (inflight_s[REQ_AUDIO]),
    .pending_o  (pending_s[REQ_AUDIO]),
    .data_o     (slot_data_s[REQ_AUDIO]),
    .overrun_o  (overrun_s[REQ_AUDIO])
  );

  spi_arb_req_slot u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (r1_tx_start),
    .data_i     (r1_tx_data),
    .clear_i    (clear_s[REQ_CFG]),
    .inflight_i (inflight_s[REQ_CFG]),
    .pending_o  (pending_s[REQ_CFG]),
    .data_o     (slot_data_s[REQ_CFG]),
    .overrun_o  (overrun_s[REQ_CFG])
  );

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic prio_q;
  logic release_s;

  // A whole lock sequence releases only once, on the return to IDLE
  assign release_s = ((state_q == ST_WAIT_FALL) || (state_q == ST_HOLD)) && (state_d == ST_IDLE);

  // Priority register: favour the requester that was not just served
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'(REQ_AUDIO);
    end else if (release_s) begin
      prio_q <= ~owner_s;
    end else begin
      prio_q <= prio_q;
    end
  end
  assign prio_s = prio_q;
`else
  assign prio_s = 1'(REQ_AUDIO);
`endif

  // Owner lock and IDLE-time winner selection
  always_comb begin
    owner_lock_s = owner_s ? r1_lock : r0_lock;
    if (pending_s[REQ_AUDIO] && pending_s[REQ_CFG]) begin
      pick_s = prio_s;
    end else begin
      pick_s = pending_s[REQ_CFG];
    end
  end

  // Arbitration FSM next-state, grant and timeout counter
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_s) begin
          grant_d = grant_of(pick_s);
          state_d = ST_ISSUE;
        end else begin
          grant_d = GRANT_NONE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_RISE;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT_RISE: begin
        // A transceiver that never raises busy still completes the byte
        if (spi_tx_busy || (cnt_q >= CNT_W'(BUSY_RISE_TIMEOUT - 1))) begin
          state_d = ST_WAIT_FALL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (!spi_tx_busy) begin
          if (owner_lock_s) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = GRANT_NONE;
          end
        end else begin
          state_d = ST_WAIT_FALL;
        end
      end
      ST_HOLD: begin
        if (pending_s[owner_s]) begin
          state_d = ST_ISSUE;
        end else if (!owner_lock_s) begin
          state_d = ST_IDLE;
          grant_d = GRANT_NONE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          grant_d    = GRANT_NONE;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GRANT_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // RX routing: owner while granted, otherwise unsolicited bytes go to audio
  always_comb begin
    if (grant_q != GRANT_NONE) begin
      rx_target_s = owner_s;
    end else begin
      rx_target_s = 1'(REQ_AUDIO);
    end
    rx0_done_d = spi_rx_done & ~rx_target_s;
    rx1_done_d = spi_rx_done & rx_target_s;
    if (rx0_done_d) begin
      rx0_data_d = spi_rx_data;
    end else begin
      rx0_data_d = rx0_data_q;
    end
    if (rx1_done_d) begin
      rx1_data_d = spi_rx_data;
    end else begin
      rx1_data_d = rx1_data_q;
    end
  end

  // Arbiter state and RX output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_NONE;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
      rx0_data_q <= 8'h00;
      rx1_data_q <= 8'h00;
      rx0_done_q <= 1'b0;
      rx1_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
      rx0_data_q <= rx0_data_d;
      rx1_data_q <= rx1_data_d;
      rx0_done_q <= rx0_done_d;
      rx1_done_q <= rx1_done_d;
    end
  end

  assign spi_tx_start = (state_q == ST_ISSUE);
  assign spi_tx_data  = (state_q == ST_ISSUE) ? slot_data_s[owner_s] : 8'h00;
  assign grant        = grant_q;
  assign lock_err     = lock_err_q;
  assign overrun_err  = |overrun_s;
  assign r0_tx_busy   = pending_s[REQ_AUDIO] | inflight_s[REQ_AUDIO];
  assign r1_tx_busy   = pending_s[REQ_CFG] | inflight_s[REQ_CFG];
  assign r0_rx_data   = rx0_data_q;
  assign r0_rx_done   = rx0_done_q;
  assign r1_rx_data   = rx1_data_q;
  assign r1_rx_done   = rx1_done_q;

endmodule

// File: tb/tb_spi_link_arbiter.sv
// Scoreboard bench for spi_link_arbiter: directed stimulus pushes expected
// wire bytes / RX deliveries, separate monitors pop and compare.
module tb_spi_link_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_tx_start = 1'b0, r1_tx_start = 1'b0;
  logic [7:0] r0_tx_data = 8'h00, r1_tx_data = 8'h00;
  logic       r0_lock = 1'b0, r1_lock = 1'b0;
  logic       r0_tx_busy, r1_tx_busy, r0_rx_done, r1_rx_done;
  logic [7:0] r0_rx_data, r1_rx_data;
  logic       spi_tx_start, spi_tx_busy, lock_err, overrun_err;
  logic [7:0] spi_tx_data;
  logic [7:0] spi_rx_data = 8'h00;
  logic       spi_rx_done = 1'b0;
  logic [1:0] grant;

  spi_link_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_tx_start(r0_tx_start), .r0_tx_data(r0_tx_data), .r0_lock(r0_lock),
    .r0_tx_busy(r0_tx_busy), .r0_rx_data(r0_rx_data), .r0_rx_done(r0_rx_done),
    .r1_tx_start(r1_tx_start), .r1_tx_data(r1_tx_data), .r1_lock(r1_lock),
    .r1_tx_busy(r1_tx_busy), .r1_rx_data(r1_rx_data), .r1_rx_done(r1_rx_done),
    .spi_tx_start(spi_tx_start), .spi_tx_data(spi_tx_data), .spi_tx_busy(spi_tx_busy),
    .spi_rx_data(spi_rx_data), .spi_rx_done(spi_rx_done),
    .grant(grant), .lock_err(lock_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [7:0] data; logic [1:0] grant; int cyc; } tx_exp_t;
  typedef struct { logic port; logic [7:0] data; int cyc; } rx_exp_t;
  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  // Transceiver model: busy rises the cycle after start for busy_len cycles
  int busy_len = 3;
  int rem = 0;
  always @(posedge clk) begin
    if (spi_tx_start && busy_len > 0) rem <= busy_len;
    else if (rem > 0) rem <= rem - 1;
  end
  assign spi_tx_busy = (rem > 0);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // TX monitor
  always @(negedge clk) begin
    tx_exp_t e;
    if (!rst && spi_tx_start) begin
      if (tx_q.size() == 0) begin
        chk("tx_unexpected", {24'd0, spi_tx_data}, 32'h100);
      end else begin
        e = tx_q.pop_front();
        chk("tx_data", {24'd0, spi_tx_data}, {24'd0, e.data});
        chk("tx_grant", {30'd0, grant}, {30'd0, e.grant});
        if (e.cyc >= 0) chk("tx_cycle", cyc, e.cyc);
      end
    end
  end

  // RX monitor
  always @(negedge clk) begin
    rx_exp_t e;
    if (!rst && (r0_rx_done || r1_rx_done)) begin
      if (rx_q.size() == 0) begin
        chk("rx_unexpected", {30'd0, r1_rx_done, r0_rx_done}, 32'h4);
      end else begin
        e = rx_q.pop_front();
        chk("rx_port", {30'd0, r1_rx_done, r0_rx_done}, e.port ? 32'h2 : 32'h1);
        chk("rx_data", {24'd0, e.port ? r1_rx_data : r0_rx_data}, {24'd0, e.data});
        chk("rx_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d, input logic [1:0] g, input int c);
    tx_exp_t e;
    e.data = d; e.grant = g; e.cyc = c;
    tx_q.push_back(e);
  endtask

  task automatic push_rx(input logic p, input logic [7:0] d, input int c);
    rx_exp_t e;
    e.port = p; e.data = d; e.cyc = c;
    rx_q.push_back(e);
  endtask

  // Called at a negedge; start(s) sampled by the next posedge
  task automatic start(input logic [1:0] which, input logic [7:0] d0, input logic [7:0] d1);
    r0_tx_start = which[0]; r0_tx_data = d0;
    r1_tx_start = which[1]; r1_tx_data = d1;
    @(negedge clk);
    r0_tx_start = 1'b0; r1_tx_start = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && grant == 2'b00 && !r0_tx_busy && !r1_tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", {31'd0, ok}, 32'd1);
    tick(2);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_tx"}, {19'd0, spi_tx_start, spi_tx_data, grant, lock_err, overrun_err}, 32'd0);
    chk({name, "_req"}, {12'd0, r0_tx_busy, r0_rx_data, r0_rx_done, r1_tx_busy, r1_rx_data, r1_rx_done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit found;

    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // 1: single byte, latency, busy tracking, overrun
    c = cyc;
    push_tx(8'hCA, 2'b01, c + 2);
    start(2'b01, 8'hCA, 8'h00);
    chk("t1_busy_pending", {31'd0, r0_tx_busy}, 32'd1);
    tick(2);
    start(2'b01, 8'hEE, 8'h00);
    chk("t1_overrun", {31'd0, overrun_err}, 32'd1);
    tick(2);
    chk("t1_busy_wait_fall", {31'd0, r0_tx_busy}, 32'd1);
    tick(1);
    chk("t1_busy_released", {31'd0, r0_tx_busy}, 32'd0);
    chk("t1_grant_none", {30'd0, grant}, 32'd0);
    drain();

    // 2: locked CA,FE with r1 waiting in between
    r0_lock = 1'b1;
    push_tx(8'hCA, 2'b01, cyc + 2);
    start(2'b01, 8'hCA, 8'h00);
    start(2'b10, 8'h00, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!r0_tx_busy) begin found = 1'b1; break; end
    end
    chk("t2_hold_reached", {31'd0, found}, 32'd1);
    chk("t2_hold_grant", {30'd0, grant}, 32'd1);
    chk("t2_r1_waiting", {31'd0, r1_tx_busy}, 32'd1);
    push_tx(8'hFE, 2'b01, cyc + 2);
    push_tx(8'h55, 2'b10, -1);
    start(2'b01, 8'hFE, 8'h00);
    r0_lock = 1'b0;
    drain();

    // 3: simultaneous starts, then a solo r0 byte, then another pair
    c = cyc;
    push_tx(8'hA1, 2'b01, c + 2);
    push_tx(8'hB1, 2'b10, c + 8);
    start(2'b11, 8'hA1, 8'hB1);
    drain();
    push_tx(8'hD0, 2'b01, cyc + 2);
    start(2'b01, 8'hD0, 8'h00);
    drain();
    c = cyc;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    push_tx(8'hB2, 2'b10, c + 2);
    push_tx(8'hA2, 2'b01, c + 8);
`else
    push_tx(8'hA2, 2'b01, c + 2);
    push_tx(8'hB2, 2'b10, c + 8);
`endif
    start(2'b11, 8'hA2, 8'hB2);
    drain();

    // 4: transceiver never raises busy
    busy_len = 0;
    c = cyc;
    push_tx(8'h11, 2'b01, c + 2);
    push_tx(8'h22, 2'b10, c + 8);
    start(2'b01, 8'h11, 8'h00);
    start(2'b10, 8'h00, 8'h22);
    tick(4);
    chk("t4_in_flight", {31'd0, r0_tx_busy}, 32'd1);
    tick(1);
    chk("t4_released", {31'd0, r0_tx_busy}, 32'd0);
    drain();
    busy_len = 3;

    // 5: lock held with no follow-up byte
    r0_lock = 1'b1;
    c = cyc;
    push_tx(8'h77, 2'b01, c + 2);
    push_tx(8'h88, 2'b10, c + 1032);
    start(2'b01, 8'h77, 8'h00);
    start(2'b10, 8'h00, 8'h88);
    found = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (lock_err) begin found = 1'b1; break; end
    end
    chk("t5_lock_err_seen", {31'd0, found}, 32'd1);
    chk("t5_lock_err_cycle", cyc, c + 1031);
    chk("t5_grant_none", {30'd0, grant}, 32'd0);
    r0_lock = 1'b0;
    tick(1);
    chk("t5_lock_err_pulse", {31'd0, lock_err}, 32'd0);
    drain();

    // 6: RX routing, then reset during WAIT_FALL
    push_rx(1'b0, 8'h3C, cyc + 1);
    spi_rx_done = 1'b1; spi_rx_data = 8'h3C;
    tick(1);
    spi_rx_done = 1'b0;
    push_tx(8'h99, 2'b10, cyc + 2);
    start(2'b10, 8'h00, 8'h99);
    tick(2);
    push_rx(1'b1, 8'h5A, cyc + 1);
    spi_rx_done = 1'b1; spi_rx_data = 8'h5A;
    tick(1);
    spi_rx_done = 1'b0;
    drain();
    push_tx(8'hAB, 2'b01, cyc + 2);
    start(2'b01, 8'hAB, 8'h00);
    start(2'b10, 8'h00, 8'hCC);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("t6_reset");
    tick(1);
    rst = 1'b0;
    tick(30);
    chk("t6_no_reissue_r1", {31'd0, r1_tx_busy}, 32'd0);
    chk("t6_grant_none", {30'd0, grant}, 32'd0);

    chk("tx_queue_empty", tx_q.size(), 32'd0);
    chk("rx_queue_empty", rx_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
